// File: rtl/spike_sequencer_pkg.sv
// spike_sequencer_pkg: state encoding and default schedule geometry for the spike sequencer.
package spike_sequencer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RUN, S_REST, S_DONE} state_e;
  localparam int DEF_STEP_CYCLES = 8;
  localparam int DEF_STEPS_PER_IMAGE = 16;
  localparam int DEF_REST_STEPS = 4;
endpackage

// File: rtl/spike_sequencer_step_timer.sv
// step_timer: cycle-within-step and step-within-phase counters with hold and clear.
module step_timer #(
  parameter int CYCLES = 8,
  parameter int STEPS = 16,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [SW-1:0] step_o,
  output logic          last_cycle_o,
  output logic          prefetch_o,
  output logic          last_step_o
);
  localparam int CW = $clog2(CYCLES);
  logic [CW-1:0] cyc_q;
  logic [SW-1:0] step_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q  <= '0;
      step_q <= '0;
    end else if (clr_i) begin
      cyc_q  <= '0;
      step_q <= '0;
    end else if (en_i) begin
      cyc_q  <= last_cycle_o ? '0 : cyc_q + CW'(1);
      step_q <= last_cycle_o ? step_q + SW'(1) : step_q;
    end
  end
  assign last_cycle_o = cyc_q == CW'(CYCLES - 1);
  assign prefetch_o   = cyc_q == CW'(CYCLES - 2);
  assign last_step_o  = step_q == SW'(STEPS - 1);
  assign step_o       = step_q;
endmodule

// File: rtl/spike_sequencer.sv
// spike_sequencer: walks the training-spike ROM, holding each word for a fixed step and
// inserting a neuron-reset rest interval after every image; pausable via pause.
module spike_sequencer
  import spike_sequencer_pkg::*;
#(
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int STEPS_PER_IMAGE = DEF_STEPS_PER_IMAGE,
  parameter int REST_STEPS = DEF_REST_STEPS,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_images,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] spike_out,
  output logic              spike_valid,
  output logic              step_strobe,
  output logic              image_start,
  output logic              neuron_reset,
  output logic [15:0]       cur_image,
  output logic              busy,
  output logic              done
);
  localparam int LIM = STEPS_PER_IMAGE > REST_STEPS ? STEPS_PER_IMAGE : REST_STEPS;
  localparam int SW = LIM > 1 ? $clog2(LIM) : 1;
  state_e state_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [15:0] cur_image_q, images_q;
  logic valid_q, strobe_q, istart_q, nreset_q, busy_q, done_q;
  logic [SW-1:0] step;
  logic last_cycle, prefetch, last_step, rest_last, phase_end, last_image, in_sched;
  assign in_sched   = state_q == S_RUN || state_q == S_REST;
  assign rest_last  = step == SW'(REST_STEPS > 0 ? REST_STEPS - 1 : 0);
  assign phase_end  = !pause && last_cycle && (state_q == S_RUN ? last_step : rest_last);
  assign last_image = cur_image_q == images_q - 16'd1;
  step_timer #(.CYCLES(STEP_CYCLES), .STEPS(STEPS_PER_IMAGE), .SW(SW)) u_timer (
    .clk(clk),
    .rst(rst),
    .en_i(!pause),
    .clr_i(!in_sched || phase_end),
    .step_o(step),
    .last_cycle_o(last_cycle),
    .prefetch_o(prefetch),
    .last_step_o(last_step)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      cur_image_q <= '0;
      images_q    <= '0;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
      istart_q    <= 1'b0;
      nreset_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          images_q    <= num_images;
          rom_addr_q  <= base_addr;
          cur_image_q <= '0;
          state_q     <= num_images == 16'd0 ? S_DONE : S_FETCH;
          busy_q      <= num_images != 16'd0;
          done_q      <= num_images == 16'd0;
        end
        S_FETCH: begin
          state_q  <= pause ? S_FETCH : S_RUN;
          valid_q  <= !pause;
          strobe_q <= !pause;
          istart_q <= !pause;
        end
        S_RUN: if (pause) begin
          valid_q  <= 1'b0;
          strobe_q <= 1'b0;
          istart_q <= 1'b0;
        end else begin
          if (prefetch) rom_addr_q <= rom_addr_q + ADDR_W'(1);
          if (!phase_end) begin
            valid_q  <= 1'b1;
            strobe_q <= last_cycle;
            istart_q <= 1'b0;
          end else if (REST_STEPS > 0) begin
            state_q  <= S_REST;
            nreset_q <= 1'b1;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            istart_q <= 1'b0;
          end else begin
            state_q     <= last_image ? S_DONE : S_RUN;
            busy_q      <= !last_image;
            done_q      <= last_image;
            cur_image_q <= last_image ? cur_image_q : cur_image_q + 16'd1;
            valid_q     <= !last_image;
            strobe_q    <= !last_image;
            istart_q    <= !last_image;
          end
        end
        // rom_addr already points at the next image, so REST hands straight back to RUN
        S_REST: if (phase_end) begin
          nreset_q    <= 1'b0;
          state_q     <= last_image ? S_DONE : S_RUN;
          busy_q      <= !last_image;
          done_q      <= last_image;
          cur_image_q <= last_image ? cur_image_q : cur_image_q + 16'd1;
          valid_q     <= !last_image;
          strobe_q    <= !last_image;
          istart_q    <= !last_image;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign rom_addr     = rom_addr_q;
  assign spike_out    = rom_data & {DATA_W{valid_q}};
  assign spike_valid  = valid_q;
  assign step_strobe  = strobe_q;
  assign image_start  = istart_q;
  assign neuron_reset = nreset_q;
  assign cur_image    = cur_image_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule

// File: tb/tb_spike_sequencer.sv
// tb_spike_sequencer: directed checks of the spike schedule against a cycle-indexed model.
module tb_spike_sequencer;
  logic clk = 1'b0, rst, start, start0, pause;
  logic [15:0] num_images, num0, base, base0, rom_addr, rom_addr0, cur_image, cur_image0;
  logic [31:0] rom_data, rom_data0, spike_out, spike_out0;
  logic spike_valid, step_strobe, image_start, neuron_reset, busy, done;
  logic spike_valid0, step_strobe0, image_start0, neuron_reset0, busy0, done0;
  logic [53:0] obs, obs0, exp;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  spike_sequencer #(.STEP_CYCLES(8), .STEPS_PER_IMAGE(4), .REST_STEPS(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_images(num_images), .base_addr(base),
    .pause(pause), .rom_addr(rom_addr), .rom_data(rom_data), .spike_out(spike_out),
    .spike_valid(spike_valid), .step_strobe(step_strobe), .image_start(image_start),
    .neuron_reset(neuron_reset), .cur_image(cur_image), .busy(busy), .done(done)
  );

  spike_sequencer #(.STEP_CYCLES(8), .STEPS_PER_IMAGE(4), .REST_STEPS(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .num_images(num0), .base_addr(base0),
    .pause(pause), .rom_addr(rom_addr0), .rom_data(rom_data0), .spike_out(spike_out0),
    .spike_valid(spike_valid0), .step_strobe(step_strobe0), .image_start(image_start0),
    .neuron_reset(neuron_reset0), .cur_image(cur_image0), .busy(busy0), .done(done0)
  );

  always @(posedge clk) begin
    rom_data  <= {16'h0, rom_addr};
    rom_data0 <= {16'h0, rom_addr0};
  end

  assign obs  = {spike_out, spike_valid, step_strobe, image_start, neuron_reset, busy, done, cur_image};
  assign obs0 = {spike_out0, spike_valid0, step_strobe0, image_start0, neuron_reset0, busy0, done0, cur_image0};

  // Expected outputs k cycles after the start edge (cycle 1 = FETCH) for 4 steps/image, 8 cycles/step.
  function automatic logic [53:0] model(int k, logic [15:0] b, int n, int rest);
    int per, done_k, img, p;
    logic [15:0] a, cur;
    logic [31:0] sp;
    logic v, st, is, nr, bz, d;
    per = (4 + rest) * 8;
    done_k = 2 + n * per;
    sp = '0; cur = '0;
    v = 0; st = 0; is = 0; nr = 0; bz = 0; d = 0;
    if (k == 1) bz = 1;
    else if (k < done_k) begin
      img = (k - 2) / per;
      p = (k - 2) % per;
      cur = 16'(img);
      bz = 1;
      if (p < 32) begin
        v = 1;
        a = b + 16'(img * 4 + p / 8);
        sp = {16'h0, a};
        st = (p % 8) == 0;
        is = p == 0;
      end else nr = 1;
    end else begin
      cur = 16'(n - 1);
      d = k == done_k;
    end
    return {sp, v, st, is, nr, bz, d, cur};
  endfunction

  task automatic kick(input logic sel, input logic [15:0] b, input logic [15:0] n);
    @(negedge clk);
    if (sel) begin start0 = 1; base0 = b; num0 = n; end
    else begin start = 1; base = b; num_images = n; end
    @(negedge clk);
    start = 0;
    start0 = 0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({obs, rom_addr, obs0, rom_addr0} !== '0) begin
      miscompares++;
      $display("FAIL reset got %h/%h %h/%h exp 0", obs, rom_addr, obs0, rom_addr0);
    end
  endtask

  task automatic test_single_run();
    kick(0, 16'h0010, 16'd2);
    for (int k = 1; k <= 99; k++) begin
      if (k > 1) @(negedge clk);
      exp = model(k, 16'h0010, 2, 2);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL single_run k=%0d got %h exp %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_zero_images();
    kick(0, 16'h0040, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      exp = (k == 1) ? 54'(1) << 16 : '0;
      vectors++;
      if ({obs, rom_addr} !== {exp, 16'h0040}) begin
        miscompares++;
        $display("FAIL zero_images k=%0d got %h/%h exp %h/0040", k, obs, rom_addr, exp);
      end
    end
  endtask

  task automatic test_pause();
    int valid11 = 0;
    kick(0, 16'h0010, 16'd1);
    for (int k = 1; k <= 57; k++) begin
      if (k > 1) @(negedge clk);
      exp = (k >= 14 && k <= 18) ? 54'(1) << 17 : model(k > 18 ? k - 5 : k, 16'h0010, 1, 2);
      if (spike_valid && spike_out == 32'h11) valid11++;
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL pause k=%0d got %h exp %h", k, obs, exp);
      end
      if (k == 13) pause = 1;
      if (k == 18) pause = 0;
    end
    vectors++;
    if (valid11 != 8) begin
      miscompares++;
      $display("FAIL pause_word_len got %0d exp 8", valid11);
    end
  endtask

  task automatic test_wrap();
    kick(0, 16'hFFFE, 16'd1);
    for (int k = 1; k <= 51; k++) begin
      if (k > 1) @(negedge clk);
      exp = model(k, 16'hFFFE, 1, 2);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL wrap k=%0d got %h exp %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    kick(0, 16'h0010, 16'd2);
    repeat (19) @(negedge clk);
    rst = 1;
    #1;
    vectors++;
    if ({obs, rom_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_run got %h/%h exp 0", obs, rom_addr);
    end
    @(negedge clk);
    rst = 0;
    kick(0, 16'h0080, 16'd1);
    for (int k = 1; k <= 51; k++) begin
      if (k > 1) @(negedge clk);
      exp = model(k, 16'h0080, 1, 2);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL restart k=%0d got %h exp %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    kick(1, 16'h0010, 16'd2);
    for (int k = 1; k <= 67; k++) begin
      if (k > 1) @(negedge clk);
      exp = model(k, 16'h0010, 2, 0);
      vectors++;
      if (obs0 !== exp) begin
        miscompares++;
        $display("FAIL back_to_back k=%0d got %h exp %h", k, obs0, exp);
      end
    end
  endtask

  initial begin
    rst = 1; start = 0; start0 = 0; pause = 0;
    num_images = 0; num0 = 0; base = 0; base0 = 0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 0;
    test_single_run();
    test_zero_images();
    test_pause();
    test_wrap();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spike_sequencer.md
# spike_sequencer

Sequences the training-spike ROM for the clocked STDP network. Each 32-bit ROM word is one time step of input spikes. For a requested number of images, the block walks the ROM address space and holds each word on the spike bus for a fixed number of clock cycles. It inserts a zero-spike rest interval after every image, with a neuron-reset flag raised during that interval. It sits between the training control logic (start/pause/done handshake) and the synchronous ROM. It replaces free-running address counting with a controlled, pausable schedule.

## Interface
- STEP_CYCLES, 8: clock cycles per time step (≥2).
- STEPS_PER_IMAGE, 16: ROM words (time steps) per image (≥1).
- REST_STEPS, 4: zero-spike time steps after each image (≥0).
- ADDR_W, 16: ROM address width.
- DATA_W, 32: spike word width.
- Clocking: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- num_images  in  16  images to present; sampled with start.
- base_addr  in  ADDR_W  first ROM word; sampled with start.
- pause  in  1  freeze schedule while high.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  DATA_W  ROM read data, valid one cycle after rom_addr.
- spike_out  out  DATA_W  equals rom_data when spike_valid is high, else 0.
- spike_valid  out  1  spike word being presented.
- step_strobe  out  1  first cycle of each presented step.
- image_start  out  1  first cycle of step 0 of each image.
- neuron_reset  out  1  high throughout REST.
- cur_image  out  16  index of the current image.
- busy  out  1  high in FETCH/RUN/REST.
- done  out  1  one-cycle pulse at run end.

## Operation
- States and transitions:
  - IDLE: on start, go to FETCH. Load rom_addr←base_addr; clear all counters.
  - If num_images==0 on start, go to DONE instead.
  - FETCH (1 cycle): rom_data settles; then go to RUN.
  - RUN: cyc_cnt counts 0..STEP_CYCLES-1.
    - spike_valid=1 for the whole step.
    - Prefetch: at cyc_cnt==STEP_CYCLES-2, rom_addr←rom_addr+1.
    - At the end of step STEPS_PER_IMAGE-1:
      - go to REST if REST_STEPS>0;
      - else go to RUN for the next image;
      - or go to DONE if this was the last image.
  - REST: REST_STEPS×STEP_CYCLES cycles; spike_valid=0, neuron_reset=1. Then go to RUN for the next image, or to DONE after the last image. No fetch is needed because rom_addr already points to the next image.
  - DONE (1 cycle): done=1, busy=0; then go to IDLE.
- Pause: while pause is high in FETCH/RUN/REST:
  - all counters and rom_addr hold;
  - spike_valid, step_strobe and image_start are 0; neuron_reset holds its state value.
  - The step resumes at the held cyc_cnt; the ROM re-reads the same address.
- rom_addr wraps from 2^ADDR_W-1 to 0 silently.
- start is ignored outside IDLE. start and pause asserted together in IDLE: the block enters FETCH and freezes there.
- rst at any point sends the block to IDLE immediately.
- Reset values: rom_addr=0, cur_image=0, all other outputs 0.
- cur_image increments on entry to RUN for the next image.

## Timing
- start sampled at edge E0:
  - FETCH is the cycle after E0;
  - the first spike_valid comes 2 cycles after E0.
- step_strobe and image_start are coincident on cyc_cnt==0 of step 0.
- Unpaused run length, start edge to done pulse: 1 + num_images×(STEPS_PER_IMAGE+REST_STEPS)×STEP_CYCLES + 1 cycles.
- spike_out is a combinational AND of rom_data with spike_valid.
- All other outputs are registered.

## Structure
- internal_defines.vh holds:
  - the state encoding (IDLE, FETCH, RUN, REST, DONE; 3-bit);
  - default STEP_CYCLES (tied to the existing time-period define);
  - STEPS_PER_IMAGE and REST_STEPS defaults.
- Sub-module `step_timer`: a cyc_cnt/step_cnt pair with enable (the inverse of pause) and clear inputs, producing last_cycle, prefetch and last_step flags.
- Counter widths are clog2 of their limits.

## Test plan
Bench ROM model returns data = address.

- Defaults STEP_CYCLES=8, STEPS_PER_IMAGE=4, REST_STEPS=2; base_addr=0x0010, num_images=2 -> spike_out shows 0x10,0x11,0x12,0x13, each for 8 cycles. Then 16 cycles of zeros with neuron_reset high. Then 0x14..0x17, then another 16 rest cycles. done is pulsed on cycle 1+2×6×8+1=98 after the start edge.
- num_images=0 -> done pulses the cycle after the start edge; spike_valid never asserts; rom_addr=base_addr.
- pause high for 5 cycles starting at cyc_cnt==3 of step 1 -> word 0x11 is presented for 8 valid cycles in total; the done pulse is delayed by exactly 5 cycles.
- base_addr=0xFFFE, num_images=1 -> words 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rst asserted mid-RUN -> all outputs are 0 in that same cycle. A start after rst is released begins cleanly from the new base_addr.
- REST_STEPS=0, num_images=2 -> the eight words are presented back-to-back; neuron_reset never asserts; image_start pulses at cycles 2 and 34.
